if_id_stage: RTL and testbench

- IF/ID pipeline register of the static 5-stage MIPS pipeline. It captures the fetched instruction and PC+4 from IF and presents them to the ID-stage control unit.
- It owns the multi-cycle stall counter that the ID control unit uses for its data-hazard stalls: it freezes PC and IF/ID, and requests a bubble into ID/EX.
- It flushes the fetched instruction on exception/trap redirects.

---
 rtl/pipe_pkg.sv | 25 ++
 rtl/stall_counter.sv | 55 +++++
 rtl/if_id_stage.sv | 99 +++++++++
 tb/tb_if_id_stage.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: NOP encoding, stall-length codes, IF/ID word layout
// and the stall-counter state type.
package pipe_pkg;

  localparam int unsigned PIPE_W = 32;

  // sll $0,$0,0
  localparam logic [PIPE_W-1:0] NOP_INSTR = 32'h0000_0000;

  // Stall lengths requested by the ID control unit
  localparam logic [1:0] STALL_EXE = 2'd3;
  localparam logic [1:0] STALL_MEM = 2'd2;

  typedef struct packed {
    logic [PIPE_W-1:0] instr;
    logic [PIPE_W-1:0] npc;
    logic              valid;
  } if_id_t;

  typedef enum logic {
    StIdle,
    StStall
  } stall_state_e;

endpackage

// File: rtl/stall_counter.sv
// Multi-cycle data-hazard stall counter. Loads max(stall_len,1)-1 on a fresh request,
// counts down to zero, and raises hold for every cycle of the stall. Flush aborts.
module stall_counter #(
  parameter int unsigned CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_req,
  input  logic [CNT_W-1:0] stall_len,
  input  logic             flush,
  output logic             hold,
  output logic [CNT_W-1:0] cnt
);
  import pipe_pkg::*;

  stall_state_e     state_q;
  logic [CNT_W-1:0] cnt_q;

  // Freeze PC and IF/ID while counting or on a fresh request; a flush always lets the
  // redirect target through.
  always_comb begin
    hold = ~flush & ((state_q == StStall) | stall_req);
  end

  assign cnt = cnt_q;

  // Counter FSM: StStall holds exactly while cnt_q != 0, so cnt never decrements past 0.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          // Lengths 0 and 1 give a single hold cycle without leaving StIdle
          if (stall_req && (stall_len > CNT_W'(1))) begin
            cnt_q   <= stall_len - CNT_W'(1);
            state_q <= StStall;
          end
        end
        StStall: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_q <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
          cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/if_id_stage.sv
// IF/ID pipeline register with stall hold, flush-to-NOP and bubble request.
// Optional build macro IF_ID_PERF_EN adds stall-cycle and flush performance counters.
// Branches/jumps never flush here: the delay-slot instruction is always kept.
module if_id_stage #(
  parameter int unsigned          DATA_W    = 32,
  parameter logic [DATA_W-1:0]    NOP_INSTR = DATA_W'(pipe_pkg::NOP_INSTR),
  parameter int unsigned          CNT_W     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] if_instr,
  input  logic [DATA_W-1:0] if_npc,
  input  logic              stall_req,
  input  logic [CNT_W-1:0]  stall_len,
  input  logic              flush,
  output logic [DATA_W-1:0] id_instr,
  output logic [DATA_W-1:0] id_npc,
  output logic              id_valid,
  output logic [CNT_W-1:0]  stall_count,
  output logic              pc_ena,
  output logic              bubble
`ifdef IF_ID_PERF_EN
  ,
  output logic [31:0]       perf_stall_cycles,
  output logic [31:0]       perf_flush_count
`endif
);
  import pipe_pkg::*;

  logic   hold;
  if_id_t if_id_q, if_id_d;

  stall_counter #(
    .CNT_W (CNT_W)
  ) u_stall_counter (
    .clk       (clk),
    .rst       (rst),
    .stall_req (stall_req),
    .stall_len (stall_len),
    .flush     (flush),
    .hold      (hold),
    .cnt       (stall_count)
  );

  assign pc_ena = ~hold;
  assign bubble = hold;

  // Next IF/ID word: flush > hold > load (reset applied in the register)
  always_comb begin
    if_id_d = if_id_q;
    if (flush) begin
      if_id_d.instr = PIPE_W'(NOP_INSTR);
      if_id_d.valid = 1'b0;
    end else if (!hold) begin
      if_id_d.instr = PIPE_W'(if_instr);
      if_id_d.npc   = PIPE_W'(if_npc);
      if_id_d.valid = 1'b1;
    end
  end

  // IF/ID register with synchronous reset to a non-valid NOP
  always_ff @(posedge clk) begin
    if (rst) begin
      if_id_q.instr <= PIPE_W'(NOP_INSTR);
      if_id_q.npc   <= '0;
      if_id_q.valid <= 1'b0;
    end else begin
      if_id_q <= if_id_d;
    end
  end

  assign id_instr = DATA_W'(if_id_q.instr);
  assign id_npc   = DATA_W'(if_id_q.npc);
  assign id_valid = if_id_q.valid;

`ifdef IF_ID_PERF_EN
  logic [31:0] perf_stall_q;
  logic [31:0] perf_flush_q;

  // Free-running event counters, wrapping modulo 2^32
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if (hold) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
      if (flush) begin
        perf_flush_q <= perf_flush_q + 32'd1;
      end
    end
  end

  assign perf_stall_cycles = perf_stall_q;
  assign perf_flush_count  = perf_flush_q;
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Scoreboard bench for if_id_stage: the driver applies one directed vector per cycle
// and queues the hand-computed outputs for that cycle; the monitor pops and compares.
module tb_if_id_stage;

  localparam logic [31:0] NOP = 32'h0000_0000;
  localparam logic [31:0] I1 = 32'h2008_0005, N1 = 32'h0040_0004;
  localparam logic [31:0] I2 = 32'h2009_0007, N2 = 32'h0040_0008;
  localparam logic [31:0] I3 = 32'h0109_5020, N3 = 32'h0040_000c;
  localparam logic [31:0] I4 = 32'h1000_0003, N4 = 32'h0040_0010;
  localparam logic [31:0] I5 = 32'h8d2a_0000, N5 = 32'h0040_0014;
  localparam logic [31:0] I6 = 32'hac0b_0004, N6 = 32'h0040_0018;
  localparam logic [31:0] I7 = 32'h0000_000c, N7 = 32'h0040_001c;
  localparam logic [31:0] I8 = 32'h2210_ffff, N8 = 32'h0040_0020;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] if_instr = '0;
  logic [31:0] if_npc = '0;
  logic        stall_req = 1'b0;
  logic [1:0]  stall_len = '0;
  logic        flush = 1'b0;
  logic [31:0] id_instr, id_npc;
  logic        id_valid, pc_ena, bubble;
  logic [1:0]  stall_count;
`ifdef IF_ID_PERF_EN
  logic [31:0] perf_stall_cycles, perf_flush_count;
`endif

  always #5 clk = ~clk;

  if_id_stage dut (
    .clk         (clk),
    .rst         (rst),
    .if_instr    (if_instr),
    .if_npc      (if_npc),
    .stall_req   (stall_req),
    .stall_len   (stall_len),
    .flush       (flush),
    .id_instr    (id_instr),
    .id_npc      (id_npc),
    .id_valid    (id_valid),
    .stall_count (stall_count),
    .pc_ena      (pc_ena),
    .bubble      (bubble)
`ifdef IF_ID_PERF_EN
    ,
    .perf_stall_cycles (perf_stall_cycles),
    .perf_flush_count  (perf_flush_count)
`endif
  );

  typedef struct {
    int          idx;
    logic [31:0] instr;
    logic [31:0] npc;
    logic        valid;
    logic [1:0]  cnt;
    logic        pc_ena;
    logic        bubble;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   vec_n = 0;

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s vec%0d got=%h want=%h", name, idx, act, want);
    end
  endtask

  // Apply one cycle of inputs and queue the outputs expected during that cycle
  task automatic vec(input logic r, input logic [31:0] ins, input logic [31:0] np,
                     input logic req, input logic [1:0] len, input logic fl,
                     input logic [31:0] e_ins, input logic [31:0] e_np, input logic e_v,
                     input logic [1:0] e_cnt, input logic e_pc, input logic e_bub);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; if_instr = ins; if_npc = np; stall_req = req; stall_len = len; flush = fl;
    e.idx = vec_n; e.instr = e_ins; e.npc = e_np; e.valid = e_v;
    e.cnt = e_cnt; e.pc_ena = e_pc; e.bubble = e_bub;
    sb.push_back(e);
    vec_n++;
  endtask

  // Monitor: compare every cycle the scoreboard has an entry, mid-cycle
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("id_instr",    e.idx, id_instr,           e.instr);
      chk("id_npc",      e.idx, id_npc,             e.npc);
      chk("id_valid",    e.idx, 32'(id_valid),      32'(e.valid));
      chk("stall_count", e.idx, 32'(stall_count),   32'(e.cnt));
      chk("pc_ena",      e.idx, 32'(pc_ena),        32'(e.pc_ena));
      chk("bubble",      e.idx, 32'(bubble),        32'(e.bubble));
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    //    rst ins np  req len fl   instr npc v cnt pc bub
    vec(0, I1, N1, 0, 0, 0,  NOP, 0,  0, 0, 1, 0); // reset state
    vec(0, I2, N2, 0, 0, 0,  I1, N1, 1, 0, 1, 0); // first load, 1-cycle latency
    vec(0, I3, N3, 1, 3, 0,  I2, N2, 1, 0, 0, 1); // EXE stall request
    vec(0, I3, N3, 0, 0, 0,  I2, N2, 1, 2, 0, 1);
    vec(0, I3, N3, 0, 0, 0,  I2, N2, 1, 1, 0, 1);
    vec(0, I3, N3, 0, 0, 0,  I2, N2, 1, 0, 1, 0); // release
    vec(0, I4, N4, 1, 2, 0,  I3, N3, 1, 0, 0, 1); // MEM stall
    vec(0, I4, N4, 0, 0, 0,  I3, N3, 1, 1, 0, 1);
    vec(0, I4, N4, 1, 3, 0,  I3, N3, 1, 0, 0, 1); // back-to-back EXE stall
    vec(0, I4, N4, 0, 0, 0,  I3, N3, 1, 2, 0, 1);
    vec(0, I4, N4, 0, 0, 0,  I3, N3, 1, 1, 0, 1);
    vec(0, I4, N4, 0, 0, 0,  I3, N3, 1, 0, 1, 0);
    vec(0, I5, N5, 1, 3, 0,  I4, N4, 1, 0, 0, 1);
    vec(0, I5, N5, 0, 0, 1,  I4, N4, 1, 2, 1, 0); // flush at cnt=2
    vec(0, I5, N5, 0, 0, 0,  NOP, N4, 0, 0, 1, 0);
    vec(0, I6, N6, 1, 3, 0,  I5, N5, 1, 0, 0, 1);
    vec(0, I6, N6, 0, 0, 0,  I5, N5, 1, 2, 0, 1);
    vec(1, I6, N6, 0, 0, 0,  I5, N5, 1, 1, 0, 1); // reset at cnt=1
    vec(0, I6, N6, 0, 0, 0,  NOP, 0,  0, 0, 1, 0); // no residual hold
    vec(0, I7, N7, 1, 0, 0,  I6, N6, 1, 0, 0, 1); // stall_len=0: one hold cycle
    vec(0, I7, N7, 0, 0, 0,  I6, N6, 1, 0, 1, 0);
    vec(0, I8, N8, 1, 3, 1,  I7, N7, 1, 0, 1, 0); // flush beats stall_req
    vec(0, I8, N8, 0, 0, 0,  NOP, N7, 0, 0, 1, 0);
    vec(0, I1, N1, 1, 3, 0,  I8, N8, 1, 0, 0, 1);
    vec(0, I1, N1, 0, 0, 0,  I8, N8, 1, 2, 0, 1);
    vec(0, I1, N1, 0, 0, 0,  I8, N8, 1, 1, 0, 1);
    vec(0, I1, N1, 0, 0, 1,  I8, N8, 1, 0, 1, 0); // flush while idle
    vec(0, I2, N2, 0, 0, 0,  NOP, N8, 0, 0, 1, 0);

    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain pending=%0d required=0", sb.size());
    end

`ifdef IF_ID_PERF_EN
    // Since the mid-run reset: holds in 4 cycles, flushes in 2 cycles
    chk("perf_stall_cycles", vec_n, perf_stall_cycles, 32'd4);
    chk("perf_flush_count",  vec_n, perf_flush_count,  32'd2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
